// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register: valid/ready handshake with a 2-entry skid buffer and a flush squash.
// Optional `define PIPE_STAGE_PERF_EN adds saturating stall/bubble cycle counters.
module pipe_stage_skid #(
    parameter int                   PAYLOAD_W     = 160,
    parameter logic [PAYLOAD_W-1:0] RESET_PAYLOAD = {PAYLOAD_W{1'b0}}
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
`ifdef PIPE_STAGE_PERF_EN
    output logic [31:0]          stall_cycles,
    output logic [31:0]          bubble_cycles,
`endif
    output logic [1:0]           occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [PAYLOAD_W-1:0] main_r;
    logic [PAYLOAD_W-1:0] main_nxt_s;
    logic [PAYLOAD_W-1:0] skid_r;
    logic [PAYLOAD_W-1:0] skid_nxt_s;
    logic                 out_valid_r;
    logic                 in_ready_r;
    logic [1:0]           occupancy_r;
    logic                 accept_s;
    logic                 emit_s;

    // Next-state and payload steering; flush squashes every entry, an Emit in that cycle is already done.
    always_comb begin
        accept_s    = in_valid & in_ready_r;
        emit_s      = out_valid_r & out_ready;
        state_nxt_s = state_r;
        main_nxt_s  = main_r;
        skid_nxt_s  = skid_r;
        if (flush) begin
            state_nxt_s = ST_EMPTY;
            main_nxt_s  = RESET_PAYLOAD;
            skid_nxt_s  = RESET_PAYLOAD;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        main_nxt_s  = in_data;
                        state_nxt_s = ST_ONE;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && emit_s) begin
                        main_nxt_s  = in_data;
                        state_nxt_s = ST_ONE;
                    end else if (accept_s) begin
                        skid_nxt_s  = in_data;
                        state_nxt_s = ST_TWO;
                    end else if (emit_s) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (emit_s) begin
                        main_nxt_s  = skid_r;
                        state_nxt_s = ST_ONE;
                    end else begin
                        state_nxt_s = ST_TWO;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                    main_nxt_s  = RESET_PAYLOAD;
                    skid_nxt_s  = RESET_PAYLOAD;
                end
            endcase
        end
    end

    // State, payload and handshake flags; flags are decoded from the next state so they stay registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_EMPTY;
            main_r      <= RESET_PAYLOAD;
            skid_r      <= RESET_PAYLOAD;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            occupancy_r <= 2'd0;
        end else begin
            state_r     <= state_nxt_s;
            main_r      <= main_nxt_s;
            skid_r      <= skid_nxt_s;
            out_valid_r <= (state_nxt_s != ST_EMPTY);
            in_ready_r  <= (state_nxt_s != ST_TWO);
            occupancy_r <= state_nxt_s;
        end
    end

    assign out_valid = out_valid_r;
    assign in_ready  = in_ready_r;
    assign out_data  = main_r;
    assign occupancy = occupancy_r;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cycles_r;
    logic [31:0] bubble_cycles_r;

    // Saturating performance counters; only reset clears them, flush cycles still count.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_r  <= 32'd0;
            bubble_cycles_r <= 32'd0;
        end else begin
            if (in_valid && !in_ready_r && (stall_cycles_r != 32'hFFFF_FFFF)) begin
                stall_cycles_r <= stall_cycles_r + 32'd1;
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
            if (!out_valid_r && out_ready && (bubble_cycles_r != 32'hFFFF_FFFF)) begin
                bubble_cycles_r <= bubble_cycles_r + 32'd1;
            end else begin
                bubble_cycles_r <= bubble_cycles_r;
            end
        end
    end

    assign stall_cycles  = stall_cycles_r;
    assign bubble_cycles = bubble_cycles_r;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and model-checked bench for pipe_stage_skid; perf counters checked when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_skid;

    localparam int W = 160;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]  stall_cycles;
    logic [31:0]  bubble_cycles;
`endif

    int num_checks = 0;
    int num_errors = 0;

    pipe_stage_skid #(.PAYLOAD_W(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
`ifdef PIPE_STAGE_PERF_EN
        .stall_cycles  (stall_cycles),
        .bubble_cycles (bubble_cycles),
`endif
        .occupancy     (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic ov, input logic ir, input logic [1:0] occ);
        check_val({tag, "_out_valid"}, W'(out_valid), W'(ov));
        check_val({tag, "_in_ready"},  W'(in_ready),  W'(ir));
        check_val({tag, "_occupancy"}, W'(occupancy), W'(occ));
    endtask

    logic [W-1:0] q[$];
    logic         m_accept;
    logic         m_emit;
    logic         hold_data;

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick();
        reset = 1'b0;
        check_state("reset", 1'b0, 1'b1, 2'd0);
        check_val("reset_data", out_data, '0);

        // Streaming with out_ready high: one cycle latency, full throughput.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i);
            tick();
            check_val($sformatf("stream_data%0d", i), out_data, W'(i));
            check_state($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1);
        end
        in_valid = 1'b0;
        tick();
        check_state("stream_drain", 1'b0, 1'b1, 2'd0);

        // Fill the skid, hold C upstream, then drain in order.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = W'(32'hA);
        tick();
        check_state("fill_a", 1'b1, 1'b1, 2'd1);
        check_val("fill_a_data", out_data, W'(32'hA));
        in_data = W'(32'hB);
        tick();
        check_state("fill_b", 1'b1, 1'b0, 2'd2);
        in_data = W'(32'hC);
        tick();
        check_state("hold_c", 1'b1, 1'b0, 2'd2);
        check_val("hold_c_data", out_data, W'(32'hA));
        out_ready = 1'b1;
        tick();
        check_val("drain_b", out_data, W'(32'hB));
        check_state("drain_b", 1'b1, 1'b1, 2'd1);
        tick();
        check_val("drain_c", out_data, W'(32'hC));
        check_state("drain_c", 1'b1, 1'b1, 2'd1);
        in_valid = 1'b0;
        tick();
        check_state("drain_end", 1'b0, 1'b1, 2'd0);

        // Flush in TWO with a concurrent accept attempt.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = W'(32'hE);
        tick();
        in_data = W'(32'hF);
        tick();
        check_state("pre_flush", 1'b1, 1'b0, 2'd2);
        flush = 1'b1; in_data = W'(32'hD); out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check_state("flush", 1'b0, 1'b1, 2'd0);
        check_val("flush_data", out_data, '0);
        tick();
        check_state("post_flush", 1'b0, 1'b1, 2'd0);
        check_val("post_flush_data", out_data, '0);

        // Reset mid-stream while holding one entry.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = W'(32'h3);
        tick();
        check_state("pre_reset", 1'b1, 1'b1, 2'd1);
        reset = 1'b1; in_data = W'(32'h9);
        tick();
        reset = 1'b0;
        check_state("mid_reset", 1'b0, 1'b1, 2'd0);
        check_val("mid_reset_data", out_data, '0);
        in_data = W'(32'h5);
        tick();
        check_state("post_reset5", 1'b1, 1'b1, 2'd1);
        check_val("post_reset5_data", out_data, W'(32'h5));
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check_state("post_reset_drain", 1'b0, 1'b1, 2'd0);

        // Random traffic against a reference FIFO.
        q.delete();
        hold_data = 1'b0;
        for (int c = 0; c < 10000 && num_errors < 20; c++) begin
            if (!hold_data) begin
                in_valid = 1'($urandom_range(1, 0));
                in_data  = {$urandom, $urandom, $urandom, $urandom, $urandom};
            end
            out_ready = 1'($urandom_range(1, 0));
            m_accept  = in_valid && (q.size() < 2);
            m_emit    = (q.size() > 0) && out_ready;
            hold_data = in_valid && !m_accept;
            if (m_emit) void'(q.pop_front());
            if (m_accept) q.push_back(in_data);
            tick();
            check_val("rnd_occupancy", W'(occupancy), W'(q.size()));
            check_val("rnd_out_valid", W'(out_valid), W'(q.size() != 0));
            if (q.size() != 0) check_val("rnd_out_data", out_data, q[0]);
        end
        in_valid = 1'b0;

`ifdef PIPE_STAGE_PERF_EN
        // Perf counters: 2 accepts then 8 stalls, flush keeps, reset clears.
        reset = 1'b1; out_ready = 1'b0;
        tick();
        reset = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = W'(i + 16);
            tick();
        end
        in_valid = 1'b0;
        check_val("perf_stall", W'(stall_cycles), W'(32'd8));
        check_val("perf_bubble0", W'(bubble_cycles), W'(32'd0));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_val("perf_stall_flush", W'(stall_cycles), W'(32'd8));
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check_val("perf_bubble3", W'(bubble_cycles), W'(32'd3));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("perf_stall_reset", W'(stall_cycles), W'(32'd0));
        check_val("perf_bubble_reset", W'(bubble_cycles), W'(32'd0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
